// File: rtl/game_pkg.sv
// Shared types for the game event recorder and the counter bench.
// Event types, WHO/ctrl codes, game phase enum, record width helper.
package game_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LOSE = 2'b01,
    WIN  = 2'b10,
    OVER = 2'b11
  } evt_type_e;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  localparam logic [1:0] UP1 = 2'b00;
  localparam logic [1:0] UP2 = 2'b01;
  localparam logic [1:0] DN1 = 2'b10;
  localparam logic [1:0] DN2 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } game_state_e;

  function automatic int rec_w(input int ts_w);
    return 4 + ts_w;
  endfunction

endpackage

// File: rtl/game_event_recorder_if.sv
// Event record stream: show-ahead data with valid/ready handshake.
// The recorder drives through master, the consumer through slave.
interface game_event_recorder_if #(
  parameter int TS_W = 16
);
  import game_pkg::*;

  logic [rec_w(TS_W)-1:0] evt_data;
  logic                   evt_valid;
  logic                   evt_ready;

  modport master (
    output evt_data,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    output evt_ready
  );

endinterface

// File: rtl/game_evt_fifo.sv
// Synchronous show-ahead FIFO for event records.
// A push into a full FIFO only lands when a pop frees the slot.
module game_evt_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CAP  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE = 1;
  localparam logic [AW-1:0] PONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CAP);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear flushes like reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PONE;
      if (do_pop)  rd_ptr <= rd_ptr + PONE;
      if (do_push && !do_pop)
        cnt <= cnt + CONE;
      else if (do_pop && !do_push)
        cnt <= cnt - CONE;
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/game_event_recorder.sv
// Timestamped recorder of counter result pulses with win/lose tallies.
// Optional GAME_ROUND_CHECK_EN adds a sticky mismatch output.
module game_event_recorder
  import game_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int TS_W         = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    init,
  input  logic                    loser,
  input  logic                    winner,
  input  logic                    gameover,
  input  logic [1:0]              who,
  game_event_recorder_if.master   evt,
  output logic [COUNTER_SIZE-1:0] win_tally,
  output logic [COUNTER_SIZE-1:0] lose_tally,
`ifdef GAME_ROUND_CHECK_EN
  output logic                    mismatch,
`endif
  output logic                    game_done,
  output logic                    overflow
);

  localparam int RW = rec_w(TS_W);
  localparam logic [COUNTER_SIZE-1:0] TMAX = '1;
  localparam logic [COUNTER_SIZE-1:0] TONE = 1;
  localparam logic [TS_W-1:0]         SONE = 1;

  game_state_e     state;
  game_state_e     state_nxt;
  logic            cap;
  logic [TS_W-1:0] ts;
  logic            rec_push;
  evt_type_e       rec_type;
  logic [1:0]      rec_who;
  logic [RW-1:0]   rec;
  logic            pop;
  logic            full;
  logic            empty;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_l) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: init restarts from anywhere, gameover ends a run.
  always_comb begin
    state_nxt = state;
    if (init)
      state_nxt = RUN;
    else if (state == RUN && gameover)
      state_nxt = DONE;
  end

  // Phase-derived outputs; events count only in RUN without init.
  always_comb begin
    game_done = (state == DONE);
    cap       = (state == RUN) && !init;
  end

  // Record selection: gameover over loser over winner.
  always_comb begin
    rec_push = 1'b0;
    rec_type = NONE;
    rec_who  = WHO_NONE;
    if (cap) begin
      if (gameover) begin
        rec_push = 1'b1;
        rec_type = OVER;
        rec_who  = who;
      end else if (loser) begin
        rec_push = 1'b1;
        rec_type = LOSE;
      end else if (winner) begin
        rec_push = 1'b1;
        rec_type = WIN;
      end
    end
  end

  assign rec           = {rec_type, rec_who, ts};
  assign pop           = evt.evt_valid && evt.evt_ready;
  assign evt.evt_valid = !empty;

  game_evt_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_l),
    .clr   (init),
    .push  (rec_push),
    .pop   (pop),
    .din   (rec),
    .dout  (evt.evt_data),
    .full  (full),
    .empty (empty)
  );

  // Timestamp, saturating tallies and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst_l || init) begin
      ts         <= '0;
      win_tally  <= '0;
      lose_tally <= '0;
      overflow   <= 1'b0;
    end else if (cap) begin
      ts <= ts + SONE;
      if (loser) begin
        if (lose_tally != TMAX)
          lose_tally <= lose_tally + TONE;
      end else if (winner) begin
        if (win_tally != TMAX)
          win_tally <= win_tally + TONE;
      end
      if (rec_push && full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef GAME_ROUND_CHECK_EN
  logic go_ok;

  assign go_ok = (who == WHO_LOSER  && lose_tally == TMAX) ||
                 (who == WHO_WINNER && win_tally  == TMAX);

  // Flag a game that ended without a saturated side, or a double pulse.
  always_ff @(posedge clk) begin
    if (rst_l || init)
      mismatch <= 1'b0;
    else if (cap) begin
      if (gameover && !go_ok)
        mismatch <= 1'b1;
      if (loser && winner)
        mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_game_event_recorder.sv
// Self-checking bench for game_event_recorder with a queue-based model.
// Directed scenarios plus a randomized run against the model.
module tb_game_event_recorder;

  localparam int CS = 4;
  localparam int TW = 16;
  localparam int FD = 8;
  localparam int RW = 4 + TW;
  localparam int TMAX = 15;

  logic          clk;
  logic          rst_l;
  logic          init;
  logic          loser;
  logic          winner;
  logic          gameover;
  logic [1:0]    who;
  logic [CS-1:0] win_tally;
  logic [CS-1:0] lose_tally;
  logic          game_done;
  logic          overflow;
`ifdef GAME_ROUND_CHECK_EN
  logic          mismatch;
`endif

  int n_checks = 0;
  int n_errors = 0;

  game_event_recorder_if #(.TS_W(TW)) evt_if ();

  game_event_recorder #(
    .COUNTER_SIZE (CS),
    .TS_W         (TW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .init       (init),
    .loser      (loser),
    .winner     (winner),
    .gameover   (gameover),
    .who        (who),
    .evt        (evt_if.master),
    .win_tally  (win_tally),
    .lose_tally (lose_tally),
`ifdef GAME_ROUND_CHECK_EN
    .mismatch   (mismatch),
`endif
    .game_done  (game_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 run, 2 done.
  logic [RW-1:0] m_q [$];
  int            m_phase;
  logic [TW-1:0] m_ts;
  int            m_win;
  int            m_lose;
  bit            m_ovf;
  bit            m_mis;

  task automatic m_clear(input int ph);
    m_q.delete();
    m_phase = ph;
    m_ts    = '0;
    m_win   = 0;
    m_lose  = 0;
    m_ovf   = 0;
    m_mis   = 0;
  endtask

  task automatic step(input bit r, input bit i, input bit l,
                      input bit w, input bit g,
                      input logic [1:0] wh, input bit rdy);
    bit            pop;
    bit            hp;
    logic [RW-1:0] rec;
    @(negedge clk);
    rst_l = r;
    init = i;
    loser = l;
    winner = w;
    gameover = g;
    who = wh;
    evt_if.evt_ready = rdy;
    pop = rdy && (m_q.size() > 0);
    if (r) m_clear(0);
    else if (i) m_clear(1);
    else begin
      if (pop) void'(m_q.pop_front());
      if (m_phase == 1) begin
        hp = 1;
        rec = '0;
        if (g) rec = {2'b11, wh, m_ts};
        else if (l) rec = {2'b01, 2'b00, m_ts};
        else if (w) rec = {2'b10, 2'b00, m_ts};
        else hp = 0;
        if (g && !((wh == 2'b01 && m_lose == TMAX) ||
                   (wh == 2'b10 && m_win == TMAX)))
          m_mis = 1;
        if (l && w) m_mis = 1;
        if (l) m_lose = (m_lose < TMAX) ? m_lose + 1 : TMAX;
        else if (w) m_win = (m_win < TMAX) ? m_win + 1 : TMAX;
        if (hp) begin
          if (m_q.size() < FD) m_q.push_back(rec);
          else m_ovf = 1;
        end
        if (g) m_phase = 2;
        m_ts = m_ts + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input bit rdy);
    step(0, 0, 0, 0, 0, 2'b00, rdy);
  endtask

  task automatic test_reset;
    step(1, 0, 1, 1, 1, 2'b01, 1);
    step(1, 0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || evt_if.evt_data !== '0) begin
      n_errors++;
      $display("FAIL reset_evt: valid=%b data=%h want 0/0",
               evt_if.evt_valid, evt_if.evt_data);
    end
    n_checks++;
    if (win_tally !== '0 || lose_tally !== '0 ||
        game_done !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out: win=%0d lose=%0d done=%b ovf=%b want 0",
               win_tally, lose_tally, game_done, overflow);
    end
    idle_step(1);
    step(0, 0, 1, 0, 0, 2'b00, 0);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || lose_tally !== '0) begin
      n_errors++;
      $display("FAIL idle_ignore: valid=%b lose=%0d want 0/0",
               evt_if.evt_valid, lose_tally);
    end
  endtask

  task automatic test_winner_records;
    logic [RW-1:0] got [$];
    logic [RW-1:0] exp [3];
    exp[0] = {2'b10, 2'b00, 16'd2};
    exp[1] = {2'b10, 2'b00, 16'd5};
    exp[2] = {2'b10, 2'b00, 16'd7};
    step(0, 1, 0, 0, 0, 2'b00, 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, (k == 2 || k == 5 || k == 7), 0, 2'b00, 1);
      if (evt_if.evt_valid) got.push_back(evt_if.evt_data);
    end
    n_checks++;
    if (got.size() != 3) begin
      n_errors++;
      $display("FAIL win_count: got %0d records want 3", got.size());
    end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== exp[k]) begin
        n_errors++;
        $display("FAIL win_rec%0d: got %h want %h", k, got[k], exp[k]);
      end
    end
    n_checks++;
    if (win_tally !== 4'd3) begin
      n_errors++;
      $display("FAIL win_tally: got %0d want 3", win_tally);
    end
  endtask

  task automatic test_overflow;
    int n;
    step(0, 1, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 0, 2'b00, 0);
    n_checks++;
    if (overflow !== 1'b1 || lose_tally !== 4'd9) begin
      n_errors++;
      $display("FAIL ovf_set: ovf=%b lose=%0d want 1/9",
               overflow, lose_tally);
    end
    n = 0;
    for (int k = 0; k < 20 && evt_if.evt_valid; k++) begin
      n_checks++;
      if (evt_if.evt_data !== {2'b01, 2'b00, 16'(n)}) begin
        n_errors++;
        $display("FAIL drain_rec%0d: got %h want %h", n,
                 evt_if.evt_data, {2'b01, 2'b00, 16'(n)});
      end
      n++;
      idle_step(1);
    end
    n_checks++;
    if (n != 8 || evt_if.evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_count: got %0d valid=%b want 8/0",
               n, evt_if.evt_valid);
    end
  endtask

  task automatic test_gameover;
    step(0, 1, 0, 0, 0, 2'b00, 1);
    for (int k = 0; k < 15; k++) step(0, 0, 1, 0, 0, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b01, 1);
    n_checks++;
    if (evt_if.evt_valid !== 1'b1 ||
        evt_if.evt_data !== {2'b11, 2'b01, 16'd15}) begin
      n_errors++;
      $display("FAIL over_rec: valid=%b data=%h want 1/%h",
               evt_if.evt_valid, evt_if.evt_data, {2'b11, 2'b01, 16'd15});
    end
    n_checks++;
    if (game_done !== 1'b1 || lose_tally !== 4'd15) begin
      n_errors++;
      $display("FAIL over_state: done=%b lose=%0d want 1/15",
               game_done, lose_tally);
    end
`ifdef GAME_ROUND_CHECK_EN
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_errors++;
      $display("FAIL over_mis: got %b want 0", mismatch);
    end
`endif
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 1, 2'b01, 1);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || lose_tally !== 4'd15 ||
        game_done !== 1'b1) begin
      n_errors++;
      $display("FAIL done_ignore: valid=%b lose=%0d done=%b want 0/15/1",
               evt_if.evt_valid, lose_tally, game_done);
    end
  endtask

  task automatic test_wrong_winner;
    step(0, 1, 0, 0, 0, 2'b00, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 2'b00, 1);
    step(0, 0, 0, 0, 1, 2'b10, 1);
    n_checks++;
    if (game_done !== 1'b1 || win_tally !== 4'd3) begin
      n_errors++;
      $display("FAIL ww_state: done=%b win=%0d want 1/3",
               game_done, win_tally);
    end
`ifdef GAME_ROUND_CHECK_EN
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_errors++;
      $display("FAIL ww_mis_set: got %b want 1", mismatch);
    end
    step(0, 1, 0, 0, 0, 2'b00, 1);
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_errors++;
      $display("FAIL ww_mis_clr: got %b want 0", mismatch);
    end
`endif
  endtask

  task automatic test_same_cycle;
    step(0, 1, 0, 0, 0, 2'b00, 0);
    idle_step(0);
    step(0, 0, 1, 0, 1, 2'b01, 0);
    n_checks++;
    if (evt_if.evt_data !== {2'b11, 2'b01, 16'd1} ||
        lose_tally !== 4'd1) begin
      n_errors++;
      $display("FAIL lose_over: data=%h lose=%0d want %h/1",
               evt_if.evt_data, lose_tally, {2'b11, 2'b01, 16'd1});
    end
    idle_step(1);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL lose_over_single: valid=%b want 0", evt_if.evt_valid);
    end
    step(0, 1, 0, 1, 0, 2'b00, 0);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || win_tally !== '0 ||
        game_done !== 1'b0) begin
      n_errors++;
      $display("FAIL init_win: valid=%b win=%0d done=%b want 0/0/0",
               evt_if.evt_valid, win_tally, game_done);
    end
  endtask

  task automatic test_reset_mid_drain;
    step(0, 1, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 2'b00, 0);
    n_checks++;
    if (evt_if.evt_valid !== 1'b1 || lose_tally !== 4'd4) begin
      n_errors++;
      $display("FAIL pre_rst: valid=%b lose=%0d want 1/4",
               evt_if.evt_valid, lose_tally);
    end
    step(1, 0, 1, 0, 0, 2'b00, 1);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || evt_if.evt_data !== '0 ||
        lose_tally !== '0 || win_tally !== '0 ||
        game_done !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst: valid=%b data=%h lose=%0d done=%b want 0",
               evt_if.evt_valid, evt_if.evt_data, lose_tally, game_done);
    end
    step(0, 0, 1, 0, 0, 2'b00, 0);
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || lose_tally !== '0) begin
      n_errors++;
      $display("FAIL post_rst_idle: valid=%b lose=%0d want 0/0",
               evt_if.evt_valid, lose_tally);
    end
  endtask

  task automatic test_random;
    logic [RW-1:0] exp_d;
    int            errs;
    step(0, 1, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(199) == 0), ($urandom_range(39) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(24) == 0), 2'($urandom_range(3)),
           ($urandom_range(2) == 0));
      exp_d = (m_q.size() > 0) ? m_q[0] : '0;
      errs = n_errors;
      n_checks++;
      if (evt_if.evt_valid !== (m_q.size() > 0) ||
          evt_if.evt_data !== exp_d) begin
        n_errors++;
        $display("FAIL rnd_evt@%0d: valid=%b data=%h want %b/%h", k,
                 evt_if.evt_valid, evt_if.evt_data, (m_q.size() > 0), exp_d);
      end
      n_checks++;
      if (win_tally !== CS'(m_win) || lose_tally !== CS'(m_lose)) begin
        n_errors++;
        $display("FAIL rnd_tally@%0d: win=%0d lose=%0d want %0d/%0d", k,
                 win_tally, lose_tally, m_win, m_lose);
      end
      n_checks++;
      if (game_done !== (m_phase == 2) || overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rnd_flags@%0d: done=%b ovf=%b want %b/%b", k,
                 game_done, overflow, (m_phase == 2), m_ovf);
      end
`ifdef GAME_ROUND_CHECK_EN
      n_checks++;
      if (mismatch !== m_mis) begin
        n_errors++;
        $display("FAIL rnd_mis@%0d: got %b want %b", k, mismatch, m_mis);
      end
`endif
      if (n_errors - errs > 0 && n_errors > 20) break;
    end
  endtask

  initial begin
    rst_l = 1'b1;
    init = 1'b0;
    loser = 1'b0;
    winner = 1'b0;
    gameover = 1'b0;
    who = 2'b00;
    evt_if.evt_ready = 1'b0;
    m_clear(0);
    test_reset;
    test_winner_records;
    test_overflow;
    test_gameover;
    test_wrong_winner;
    test_same_cycle;
    test_reset_mid_drain;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
